// File: rtl/burst_buffer_slave.sv
// -----------------------------------------------------------------------------
// burst_buffer_slave
//
// Downstream endpoint of the APB-to-burst bridge. Write bursts arriving on the
// burst_valid/burst_ready handshake are stored in a circular buffer. They are
// returned in order as read bursts on the db_valid/db_ready handshake. The
// burst_last output marks the final beat of each read burst.
//
// Ports
//   clk             in   1        single clock, rising edge
//   rst_n           in   1        asynchronous reset, active-low
//   burst_valid     in   1        write beat valid
//   data_burst_out  in   DATA_W   write beat data
//   db_length       in   LEN_W    burst length-1 (write start and rd_req)
//   last            in   1        final write beat marker
//   burst_ready     out  1        write beat accepted on valid&ready
//   rd_req          in   1        one-cycle read-burst request
//   db_valid        out  1        read beat valid
//   data_burst_in   out  DATA_W   read beat data
//   burst_last      out  1        final read beat marker
//   db_ready        in   1        read beat consumed on valid&ready
//   level           out  PTR_W+1  committed beats held in the buffer
//   len_err         out  1        sticky: last disagreed with db_length
//   err_clr         in   1        clears len_err (BURST_SLV_ERR_CLR_EN only)
//
// Configuration macro
//   BURST_SLV_ERR_CLR_EN
//     Defined:   adds err_clr. A set event in the same cycle wins over a clear.
//     Undefined: len_err is cleared only by rst_n.
// -----------------------------------------------------------------------------
module burst_buffer_slave #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       burst_valid,
  input  logic [DATA_W-1:0]          data_burst_out,
  input  logic [LEN_W-1:0]           db_length,
  input  logic                       last,
  output logic                       burst_ready,
  input  logic                       rd_req,
  output logic                       db_valid,
  output logic [DATA_W-1:0]          data_burst_in,
  output logic                       burst_last,
  input  logic                       db_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       len_err
`ifdef BURST_SLV_ERR_CLR_EN
  ,
  input  logic                       err_clr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  // Wide enough to hold both DEPTH-level and db_length+1 without overflow.
  localparam int CMP_W = LVL_W + LEN_W + 1;

  typedef enum logic [0:0] {
    W_IDLE,
    W_DATA
  } wState_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rState_t;

  wState_t           wState_q, wState_d;
  rState_t           rState_q, rState_d;
  logic [LEN_W-1:0]  wCnt_q, wCnt_d;
  logic [LEN_W-1:0]  rLen_q, rLen_d;
  logic [LEN_W-1:0]  rCnt_q, rCnt_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              lenErr_q, lenErr_d;
  logic              active_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wrFire;
  logic              rdFire;
  logic              lenErrSet;
  logic              errClr;
  logic [CMP_W-1:0]  freeSlots;
  logic [CMP_W-1:0]  wrNeed;
  logic [CMP_W-1:0]  rdNeed;

`ifdef BURST_SLV_ERR_CLR_EN
  assign errClr = err_clr;
`else
  assign errClr = 1'b0;
`endif

  assign freeSlots = CMP_W'(DEPTH) - CMP_W'(level_q);
  assign wrNeed    = CMP_W'(db_length) + CMP_W'(1);
  assign rdNeed    = CMP_W'(rLen_q) + CMP_W'(1);

  // active_q keeps burst_ready low while reset is held. It opens the write
  // side on the first edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // Write FSM next state. In W_IDLE the whole burst is reserved up front, so
  // W_DATA can accept every beat without re-checking space. wCnt holds the
  // number of beats still owed after the current one.
  always_comb begin
    wState_d    = wState_q;
    wCnt_d      = wCnt_q;
    burst_ready = 1'b0;
    lenErrSet   = 1'b0;
    case (wState_q)
      W_IDLE: begin
        burst_ready = active_q && (freeSlots >= wrNeed);
        if (burst_valid && burst_ready) begin
          if ((db_length == '0) || last) begin
            lenErrSet = (db_length == '0) != last;
          end else begin
            wCnt_d   = db_length - LEN_W'(1);
            wState_d = W_DATA;
          end
        end
      end
      W_DATA: begin
        burst_ready = 1'b1;
        if (burst_valid) begin
          if ((wCnt_q == '0) || last) begin
            lenErrSet = (wCnt_q == '0) != last;
            wState_d  = W_IDLE;
          end else begin
            wCnt_d = wCnt_q - LEN_W'(1);
          end
        end
      end
      default: begin
        wState_d = W_IDLE;
      end
    endcase
  end

  assign wrFire = burst_valid && burst_ready;

  // Read FSM next state. The read waits until the whole burst is already in the
  // buffer. Once streaming starts, it can never stall on an empty buffer.
  always_comb begin
    rState_d   = rState_q;
    rLen_d     = rLen_q;
    rCnt_d     = rCnt_q;
    db_valid   = 1'b0;
    burst_last = 1'b0;
    rdFire     = 1'b0;
    case (rState_q)
      R_IDLE: begin
        if (rd_req) begin
          rLen_d   = db_length;
          rState_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (CMP_W'(level_q) >= rdNeed) begin
          rCnt_d   = '0;
          rState_d = R_DATA;
        end
      end
      R_DATA: begin
        db_valid   = 1'b1;
        burst_last = (rCnt_q == rLen_q);
        if (db_ready) begin
          rdFire = 1'b1;
          rCnt_d = rCnt_q + LEN_W'(1);
          if (burst_last) begin
            rState_d = R_IDLE;
          end
        end
      end
      default: begin
        rState_d = R_IDLE;
      end
    endcase
  end

  assign data_burst_in = db_valid ? mem_q[rdPtr_q] : '0;

  // Pointers, level and the sticky error. A write and a read in the same
  // cycle cancel out in level. A set of len_err takes priority over err_clr.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    level_d  = level_q;
    lenErr_d = lenErr_q;
    if (wrFire) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (rdFire) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (wrFire && !rdFire) begin
      level_d = level_q + LVL_W'(1);
    end else if (!wrFire && rdFire) begin
      level_d = level_q - LVL_W'(1);
    end
    if (lenErrSet) begin
      lenErr_d = 1'b1;
    end else if (errClr) begin
      lenErr_d = 1'b0;
    end
  end

  // Control state register. Reset aborts any burst in flight on either side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wState_q <= W_IDLE;
      rState_q <= R_IDLE;
      wCnt_q   <= '0;
      rLen_q   <= '0;
      rCnt_q   <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      level_q  <= '0;
      lenErr_q <= 1'b0;
    end else begin
      wState_q <= wState_d;
      rState_q <= rState_d;
      wCnt_q   <= wCnt_d;
      rLen_q   <= rLen_d;
      rCnt_q   <= rCnt_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      level_q  <= level_d;
      lenErr_q <= lenErr_d;
    end
  end

  // Buffer storage has no reset. Entries are only visible once level counts them.
  always_ff @(posedge clk) begin
    if (wrFire) begin
      mem_q[wrPtr_q] <= data_burst_out;
    end
  end

  assign level   = level_q;
  assign len_err = lenErr_q;

endmodule

// File: tb/tb_burst_buffer_slave.sv
module tb_burst_buffer_slave;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              burst_valid;
  logic [DATA_W-1:0] data_burst_out;
  logic [LEN_W-1:0]  db_length;
  logic              last;
  logic              burst_ready;
  logic              rd_req;
  logic              db_valid;
  logic [DATA_W-1:0] data_burst_in;
  logic              burst_last;
  logic              db_ready;
  logic [$clog2(DEPTH):0] level;
  logic              len_err;
`ifdef BURST_SLV_ERR_CLR_EN
  logic              err_clr;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Scoreboard: every accepted write beat is pushed into modelQ. Every read
  // request pushes its length into lenQ. The monitor pops both on each handshake.
  logic [DATA_W-1:0] modelQ[$];
  int                lenQ[$];
  int                beatCnt = 0;

  burst_buffer_slave #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .burst_valid   (burst_valid),
    .data_burst_out(data_burst_out),
    .db_length     (db_length),
    .last          (last),
    .burst_ready   (burst_ready),
    .rd_req        (rd_req),
    .db_valid      (db_valid),
    .data_burst_in (data_burst_in),
    .burst_last    (burst_last),
    .db_ready      (db_ready),
    .level         (level),
    .len_err       (len_err)
`ifdef BURST_SLV_ERR_CLR_EN
    ,
    .err_clr       (err_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // The monitor samples on the falling edge, where a valid&ready handshake
  // predicts the transfer at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && db_valid && db_ready) begin
      if (modelQ.size() == 0 || lenQ.size() == 0) begin
        checkOutput("unexpected read beat", 32'd1, 32'd0);
      end else begin
        checkOutput("read data", data_burst_in, modelQ.pop_front());
        checkOutput("read last", {31'd0, burst_last},
                    {31'd0, beatCnt == lenQ[0]});
        if (beatCnt == lenQ[0]) begin
          void'(lenQ.pop_front());
          beatCnt = 0;
        end else begin
          beatCnt++;
        end
      end
    end
  end

  // Drive one write beat and hold it until it is accepted.
  task automatic applyStimulus(input logic [DATA_W-1:0] data,
                               input logic [LEN_W-1:0] len,
                               input logic lastFlag);
    int waitCycles = 0;
    burst_valid    = 1'b1;
    data_burst_out = data;
    db_length      = len;
    last           = lastFlag;
    forever begin
      @(negedge clk);
      if (burst_ready) break;
      waitCycles++;
      if (waitCycles > 200) begin
        checkOutput("write accept timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (waitCycles <= 200) modelQ.push_back(data);
    burst_valid = 1'b0;
    last        = 1'b0;
  endtask

  task automatic writeBurst(input logic [DATA_W-1:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      applyStimulus(base + DATA_W'(i), LEN_W'(len), i == len);
    end
  endtask

  task automatic requestRead(input int len);
    db_length = LEN_W'(len);
    rd_req    = 1'b1;
    lenQ.push_back(len);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic waitDrain();
    int cycles = 0;
    while (lenQ.size() != 0) begin
      @(negedge clk);
      #1;
      cycles++;
      if (cycles > 300) begin
        checkOutput("read drain timeout", lenQ.size(), 32'd0);
        lenQ.delete();
        beatCnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    burst_valid    = 1'b0;
    data_burst_out = '0;
    db_length      = '0;
    last           = 1'b0;
    rd_req         = 1'b0;
    db_ready       = 1'b0;
`ifdef BURST_SLV_ERR_CLR_EN
    err_clr        = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset burst_ready", {31'd0, burst_ready}, 32'd0);
    checkOutput("reset db_valid", {31'd0, db_valid}, 32'd0);
    checkOutput("reset burst_last", {31'd0, burst_last}, 32'd0);
    checkOutput("reset data", data_burst_in, 32'd0);
    checkOutput("reset level", level, 32'd0);
    checkOutput("reset len_err", {31'd0, len_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    db_length = 4'd3;
    #1;
    checkOutput("ready after reset", {31'd0, burst_ready}, 32'd1);

    // Four-beat write followed by a four-beat read
    db_ready = 1'b1;
    writeBurst(32'hA0, 3);
    checkOutput("level after 4 writes", level, 32'd4);
    requestRead(3);
    waitDrain();
    checkOutput("level after read", level, 32'd0);

    // Back-pressure holds the presented beat
    writeBurst(32'hB0, 3);
    db_ready = 1'b0;
    requestRead(3);
    begin
      int cycles = 0;
      while (!db_valid && cycles < 50) begin
        @(negedge clk);
        cycles++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall valid", {31'd0, db_valid}, 32'd1);
      checkOutput("stall data", data_burst_in, 32'hB0);
      checkOutput("stall last", {31'd0, burst_last}, 32'd0);
    end
    @(posedge clk);
    #1;
    db_ready = 1'b1;
    waitDrain();
    checkOutput("level after stalled read", level, 32'd0);

    // Full buffer and pointer wrap
    for (int b = 0; b < 4; b++) writeBurst(32'h100 + 32'(b * 16), 3);
    checkOutput("level full", level, 32'd16);
    db_length = 4'd0;
    #1;
    checkOutput("ready when full", {31'd0, burst_ready}, 32'd0);
    requestRead(15);
    waitDrain();
    checkOutput("level after full read", level, 32'd0);
    writeBurst(32'h200, 13);
    checkOutput("level 14", level, 32'd14);
    db_length = 4'd3;
    #1;
    checkOutput("ready with 2 free", {31'd0, burst_ready}, 32'd0);
    requestRead(1);
    waitDrain();
    checkOutput("level 12", level, 32'd12);
    db_length = 4'd3;
    #1;
    checkOutput("ready with 4 free", {31'd0, burst_ready}, 32'd1);
    writeBurst(32'h300, 3);
    checkOutput("level full again", level, 32'd16);
    requestRead(15);
    waitDrain();
    checkOutput("level after wrap read", level, 32'd0);

    // Early last and a read that must wait for data
    rd_req = 1'b1;
    lenQ.push_back(3);
    applyStimulus(32'hC0, 4'd3, 1'b0);
    rd_req = 1'b0;
    applyStimulus(32'hC1, 4'd3, 1'b1);
    checkOutput("len_err set", {31'd0, len_err}, 32'd1);
    checkOutput("level short burst", level, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("read waits", {31'd0, db_valid}, 32'd0);
    checkOutput("level still 2", level, 32'd2);
    writeBurst(32'hC2, 1);
    waitDrain();
    checkOutput("level after waited read", level, 32'd0);

    // Reset during beat three of a read
    writeBurst(32'hD0, 3);
    requestRead(3);
    begin
      int cycles = 0;
      forever begin
        @(posedge clk);
        #1;
        if (beatCnt == 2) break;
        cycles++;
        if (cycles > 50) begin
          checkOutput("reach beat 3 timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort db_valid", {31'd0, db_valid}, 32'd0);
    checkOutput("abort level", level, 32'd0);
    checkOutput("abort len_err", {31'd0, len_err}, 32'd0);
    modelQ.delete();
    lenQ.delete();
    beatCnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'hE0, 4'd1, 1'b1);
    checkOutput("len_err early last", {31'd0, len_err}, 32'd1);
`ifdef BURST_SLV_ERR_CLR_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    checkOutput("len_err cleared", {31'd0, len_err}, 32'd0);
`else
    repeat (3) @(posedge clk);
    #1;
    checkOutput("len_err sticky", {31'd0, len_err}, 32'd1);
`endif
    requestRead(0);
    waitDrain();
    checkOutput("final level", level, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
